// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : requester identity (instruction fetch / data)
//   MEM_READ / MEM_WRITE : encoding of mem_rw
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : a tie always goes to the data port
//   defined   : a tie goes to the requester that was not granted last
// Ports:
//   if_req, d_req : request lines
//   last_grant    : requester granted on the most recent transfer
//   pick_src      : selected requester (valid only when pick_valid)
//   pick_valid    : at least one request present
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     if_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output arb_src_t pick_src,
  output logic     pick_valid
);

  always_comb begin
    pick_valid = if_req | d_req;
    pick_src   = SRC_D;
    if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_src = (last_grant == SRC_D) ? SRC_IF : SRC_D;
`else
      pick_src = SRC_D;
`endif
    end else if (if_req) begin
      pick_src = SRC_IF;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for history; keep the port for a uniform interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// One transaction in flight at a time; grant is combinational in ARB_IDLE.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (tie-break policy, see mem_arb_pick).
// Ports:
//   clk, nreset            : clock, asynchronous active-high reset
//   if_req/if_addr         : fetch request; if_gnt accept, if_rvalid/if_rdata completion
//   d_req/d_rw/d_addr/d_wdata : data request; d_gnt accept, d_rvalid/d_rdata completion
//   mem_req/mem_rw/mem_addr/mem_wdata : shared memory request
//   mem_rdata/mem_ready    : memory response
//   busy                   : a transaction is in flight
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  arb_src_t last_grant;
  arb_src_t pick_src;
  logic     pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_src_t last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = SRC_D;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .pick_src   (pick_src),
    .pick_valid (pick_valid)
  );

  // Grants are gated by reset so every output reads 0 while nreset is high.
  assign if_gnt = !nreset && (state_q == ARB_IDLE) && pick_valid && (pick_src == SRC_IF);
  assign d_gnt  = !nreset && (state_q == ARB_IDLE) && pick_valid && (pick_src == SRC_D);
  assign busy   = (state_q != ARB_IDLE);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (if_gnt) begin
          state_d     = ARB_IF;
          mem_req_d   = 1'b1;
          mem_rw_d    = MEM_READ;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = SRC_IF;
`endif
        end else if (d_gnt) begin
          state_d     = ARB_D;
          mem_req_d   = 1'b1;
          mem_rw_d    = d_rw;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = SRC_D;
`endif
        end
      end
      ARB_IF: begin
        if (mem_ready) begin
          state_d     = ARB_IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      ARB_D: begin
        if (mem_ready) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          if (mem_rw_q == MEM_READ) d_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= SRC_D;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
